// File: rtl/fifo_ctrl_v2.sv
// Show-ahead synchronous FIFO with occupancy count, threshold flags, flush and
// sticky overflow/underflow error flags.
module fifo_ctrl_v2 #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int PTR_SIZE = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wen,
    input  logic [WIDTH-1:0]    wData,
    input  logic                pop,
    output logic [WIDTH-1:0]    rData,
    output logic                isFull,
    output logic                isEmpty,
    output logic                almostFull,
    output logic                almostEmpty,
    output logic [PTR_SIZE:0]   count,
    output logic                overflow,
    output logic                underflow,
    input  logic                clrErr
);

    localparam logic [PTR_SIZE:0] AF_THR = (PTR_SIZE+1)'(AF_LEVEL);
    localparam logic [PTR_SIZE:0] AE_THR = (PTR_SIZE+1)'(AE_LEVEL);

    logic [PTR_SIZE:0]   w_stat_q, w_stat_d;
    logic [PTR_SIZE:0]   r_stat_q, r_stat_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [WIDTH-1:0]    ram_q [DEPTH];

    logic [PTR_SIZE-1:0] w_ptr, r_ptr;
    logic                push_acc, pop_acc;
    logic                ovf_set, unf_set;

    assign w_ptr = w_stat_q[PTR_SIZE-1:0];
    assign r_ptr = r_stat_q[PTR_SIZE-1:0];

    // Equal low bits with differing wrap bits means the writer is a full lap ahead.
    assign isEmpty     = (w_stat_q == r_stat_q);
    assign isFull      = (w_ptr == r_ptr) && (w_stat_q[PTR_SIZE] != r_stat_q[PTR_SIZE]);
    assign count       = w_stat_q - r_stat_q;
    assign almostFull  = (count >= AF_THR);
    assign almostEmpty = (count <= AE_THR);
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign rData       = isEmpty ? '0 : ram_q[r_ptr];

    // A push into a full FIFO is safe when the head leaves on the same edge.
    always_comb begin
        push_acc = !flush && wen && (!isFull || pop);
        pop_acc  = !flush && pop && !isEmpty;
        ovf_set  = !flush && wen && !push_acc;
        unf_set  = !flush && pop && isEmpty;
    end

    always_comb begin
        w_stat_d = w_stat_q;
        r_stat_d = r_stat_q;
        if (flush) begin
            w_stat_d = '0;
            r_stat_d = '0;
        end else begin
            if (push_acc) w_stat_d = w_stat_q + 1'b1;
            if (pop_acc)  r_stat_d = r_stat_q + 1'b1;
        end
        ovf_d = (ovf_q && !clrErr) || ovf_set;
        unf_d = (unf_q && !clrErr) || unf_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_stat_q <= '0;
            r_stat_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            w_stat_q <= w_stat_d;
            r_stat_q <= r_stat_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_acc) ram_q[w_ptr] <= wData;
    end

endmodule

// File: tb/tb_fifo_ctrl_v2.sv
// Directed self-checking bench for fifo_ctrl_v2 (WIDTH=32, DEPTH=8, AF=6, AE=1).
module tb_fifo_ctrl_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, wen, pop, clrErr;
    logic [31:0] wData;
    logic [31:0] rData;
    logic        isFull, isEmpty, almostFull, almostEmpty, overflow, underflow;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    int mq[$];

    fifo_ctrl_v2 #(.WIDTH(32), .DEPTH(8), .PTR_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wData(wData), .pop(pop),
        .rData(rData), .isFull(isFull), .isEmpty(isEmpty), .almostFull(almostFull),
        .almostEmpty(almostEmpty), .count(count), .overflow(overflow),
        .underflow(underflow), .clrErr(clrErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; wen = 0; pop = 0; clrErr = 0; wData = '0;
    endtask

    task automatic push_word(input logic [31:0] d);
        wen = 1; wData = d; cyc(); wen = 0;
    endtask

    task automatic pop_word();
        pop = 1; cyc(); pop = 0;
    endtask

    initial begin
        logic exp_push;
        rst = 0;
        idle_inputs();
        #3;
        check("rst_count", count, 0);
        check("rst_empty", isEmpty, 1);
        check("rst_full", isFull, 0);
        check("rst_aempty", almostEmpty, 1);
        check("rst_afull", almostFull, 0);
        check("rst_rdata", rData, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        #19 rst = 1;
        cyc();
        check("idle_count", count, 0);
        check("idle_empty", isEmpty, 1);

        // fill to full, observing threshold flags
        for (int i = 1; i <= 8; i++) begin
            push_word(32'h11 * i);
            check("fill_count", count, i);
            check("fill_afull", almostFull, (i >= 6));
            check("fill_aempty", almostEmpty, (i <= 1));
            check("fill_full", isFull, (i == 8));
        end
        check("full_head", rData, 32'h11);
        push_word(32'h99);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_head", rData, 32'h11);
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", rData, 32'h11 * i);
            pop_word();
            check("drain_count", count, 8 - i);
        end
        check("drain_empty", isEmpty, 1);
        check("drain_rdata", rData, 0);
        check("drain_unf", underflow, 0);
        clrErr = 1; cyc(); clrErr = 0;
        check("clr_ovf", overflow, 0);

        // push while full with simultaneous pop
        for (int i = 1; i <= 8; i++) push_word(32'h11 * i);
        wen = 1; wData = 32'hAA; pop = 1; cyc(); wen = 0; pop = 0;
        check("fullpp_count", count, 8);
        check("fullpp_head", rData, 32'h22);
        check("fullpp_ovf", overflow, 0);
        for (int i = 0; i < 7; i++) pop_word();
        check("fullpp_tail", rData, 32'hAA);
        check("fullpp_cnt1", count, 1);
        pop_word();
        check("fullpp_empty", isEmpty, 1);

        // push and pop on empty: push wins, pop flagged
        wen = 1; wData = 32'h5; pop = 1; cyc(); wen = 0; pop = 0;
        check("emptypp_count", count, 1);
        check("emptypp_data", rData, 32'h5);
        check("emptypp_unf", underflow, 1);
        clrErr = 1; cyc(); clrErr = 0;
        check("clr_unf", underflow, 0);
        check("clr_keep_cnt", count, 1);
        pop_word();

        // flush keeps error flags and drops same-cycle push
        pop_word();
        check("pre_flush_unf", underflow, 1);
        for (int i = 1; i <= 5; i++) push_word(32'h30 + i);
        check("pre_flush_cnt", count, 5);
        flush = 1; wen = 1; wData = 32'hEE; cyc(); flush = 0; wen = 0;
        check("flush_count", count, 0);
        check("flush_empty", isEmpty, 1);
        check("flush_rdata", rData, 0);
        check("flush_unf", underflow, 1);
        check("flush_ovf", overflow, 0);
        cyc();
        check("flush_nostore", count, 0);
        clrErr = 1; cyc(); clrErr = 0;
        flush = 1; pop = 1; cyc(); flush = 0; pop = 0;
        check("flush_pop_unf", underflow, 0);

        // mixed stream across pointer wrap against a queue model
        for (int i = 0; i < 20; i++) begin
            wen = 1; wData = 32'h100 + i; pop = (i >= 3);
            check("wrap_head", rData, (mq.size() > 0) ? mq[0] : 0);
            exp_push = (mq.size() < 8) || pop;
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (exp_push) mq.push_back(32'h100 + i);
            cyc();
            check("wrap_count", count, mq.size());
        end
        wen = 0; pop = 0;
        check("wrap_final_head", rData, mq[0]);

        // async reset mid-stream, observed before any clock edge
        wen = 1; wData = 32'h777;
        #2 rst = 0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", isEmpty, 1);
        check("arst_rdata", rData, 0);
        cyc();
        check("arst_hold_cnt", count, 0);
        wen = 0;
        rst = 1;
        cyc();
        check("arst_release", count, 0);
        check("arst_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_v2.md
Name: fifo_ctrl_v2

Overview:
Parametrised synchronous show-ahead FIFO for pipeline decoupling, e.g. between fetch and decode. It is the next generation of the team's basic FIFO and adds:
- Generic WIDTH/DEPTH.
- Occupancy count.
- Programmable almost-full/almost-empty thresholds.
- Synchronous flush for branch/exception squash.
- Push-while-full when a pop happens in the same cycle.
- Sticky overflow/underflow error flags.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 8, number of entries; must be a power of two, >= 2
PTR_SIZE, 3, log2(DEPTH); pointer width
AF_LEVEL, 6, almostFull asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almostEmpty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of all entries
wen  input  1  push request
wData  input  WIDTH  push data
pop  input  1  pop request; consumes the current rData
rData  output  WIDTH  head entry (show-ahead); 0 when empty
isFull  output  1  count == DEPTH
isEmpty  output  1  count == 0
almostFull  output  1  count >= AF_LEVEL
almostEmpty  output  1  count <= AE_LEVEL
count  output  PTR_SIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push was rejected
underflow  output  1  sticky: pop was rejected
clrErr  input  1  synchronous clear of overflow/underflow

Behaviour:
- State: wStat, rStat, each PTR_SIZE+1 bits (extra wrap bit); storage ram[DEPTH] of WIDTH bits.
- wPtr/rPtr are the low PTR_SIZE bits. count = wStat - rStat, modulo 2^(PTR_SIZE+1).
- All flags and count are combinational from the registered state. They reflect the state after the last clock edge and have no additional latency.
- rData is combinational ram[rPtr], forced to 0 when isEmpty. A pushed word is visible on rData the cycle after the push edge.
- Reset (rst low, async): wStat=rStat=0, overflow=underflow=0. Resulting outputs: count=0, isEmpty=1, isFull=0, almostEmpty=1, almostFull=(AF_LEVEL==0 ? 1 : 0), rData=0. RAM contents are not reset.
- Reset mid-operation discards all entries immediately; in-flight wen/pop are ignored while rst is low.
- Priority each edge: flush > push/pop.
- flush=1: wStat=rStat=0; wen and pop in that cycle are ignored and never set error flags. overflow/underflow are preserved unless clrErr=1.
- Push accepted when wen && (!isFull || pop): write ram[wPtr]=wData, wStat+1.
- Pop accepted when pop && !isEmpty: rStat+1.
- Full + wen + pop: both accepted; count stays DEPTH. Write to wPtr (== rPtr) is safe because the head is consumed on the same edge.
- Empty + wen + pop: push accepted, pop rejected (no bypass); count becomes 1; underflow set.
- Push rejected: overflow <= 1. Pop rejected: underflow <= 1.
- clrErr=1 clears both flags. If a new error occurs in the same cycle, set wins.
- Pointers wrap modulo 2^(PTR_SIZE+1). Full/empty are distinguished by the wrap bit: full when low bits are equal and wrap bits differ.
- No combinational path from wen/pop/wData to any output.

Test Plan:
- Reset then idle -> count=0, isEmpty=1, almostEmpty=1, rData=0, overflow=underflow=0.
- Push 0x11..0x88 (8 words, DEPTH=8) -> isFull=1, count=8, almostFull asserted from count 6; 9th push 0x99 -> rejected, overflow=1, count=8; pop 8 -> rData sequence 0x11..0x88, then isEmpty.
- Full FIFO, wen=1 wData=0xAA with pop=1 for one cycle -> count stays 8, head advances to 0x22; after 7 more pops rData=0xAA.
- Empty FIFO, wen=1 wData=0x5 and pop=1 together -> count=1, rData=0x5 next cycle, underflow=1; clrErr pulse -> underflow=0.
- 5 entries held, flush=1 with wen=1 -> count=0, isEmpty=1, new word not stored, error flags unchanged.
- 20 push/pop cycles crossing wrap, then rst low mid-stream -> ordering preserved until reset; after async reset count=0 immediately, without waiting for a clock edge.
